quote_order_dispatcher: RTL and testbench
=========================================

Name: quote_order_dispatcher

Overview:
Downstream consumer of the quote pricing stage. Takes integer bid/ask quote pairs (valid-only, no backpressure) and converts them into a serial stream of CANCEL/NEW order messages over a valid/ready interface. Suppresses unchanged sides, tracks live order IDs, and enforces a minimum inter-requote gap. Holds only the newest quote while busy and counts quotes it overwrites.

Parameters:
DATA_WIDTH, 32, price width; matches the pricing stage output.
QTY_WIDTH, 16, order quantity width.
ID_WIDTH, 16, order ID width.
MIN_GAP_CYCLES, 8, idle cycles enforced after a requote sequence sends at least one message.
PRICE_TOL, 0, unsigned tick tolerance; a side is requoted only if |new - live| > PRICE_TOL.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_buy_price  in  DATA_WIDTH  bid quote, integer ticks
i_ask_price  in  DATA_WIDTH  ask quote, integer ticks
i_quote_qty  in  QTY_WIDTH  quantity for both sides, sampled with the quote
i_data_valid  in  1  quote valid, single-cycle pulse, no backpressure
o_order_valid  out  1  message valid
i_order_ready  in  1  downstream accepts message
o_order_type  out  1  0=NEW, 1=CANCEL
o_order_side  out  1  0=bid, 1=ask
o_order_price  out  DATA_WIDTH  price (NEW); 0 for CANCEL
o_order_qty  out  QTY_WIDTH  qty (NEW); 0 for CANCEL
o_order_id  out  ID_WIDTH  ID of new order, or of order being cancelled
o_busy  out  1  FSM not in IDLE
o_drop_count  out  16  saturating count of overwritten pending quotes
o_reject_count  out  16  saturating count of rejected quotes

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM=IDLE; pending empty; live bid/ask IDs 0 (0 = no live order); next ID=1; gap counter 0.
- Intake: on i_data_valid, reject if bid==0 or bid>=ask (reject_count++, pending untouched). Otherwise write to the single-entry pending slot. If the slot is already full and not consumed this cycle, increment drop_count. A write in the same cycle the FSM consumes the slot stores the new quote with no drop.
- FSM states: IDLE, CXL_BID, NEW_BID, CXL_ASK, NEW_ASK, GAP.
- Leaving IDLE: requires pending full and gap counter 0. Consume the slot and latch the quote. A side changes if its live ID is 0 or |new - live price| > PRICE_TOL.
  - Visit states in order CXL_BID, NEW_BID, CXL_ASK, NEW_ASK.
  - CXL_x only if side x changes and its live ID != 0.
  - NEW_x only if side x changes.
  - If no side changes: return to IDLE with no messages and no gap.
- Message states: drive a registered message with o_order_valid=1. Payload is stable until the cycle with valid&&ready. Advance on that handshake.
  - After CANCEL: set live ID to 0.
  - After NEW: set live ID/price to the new values; next ID increments, wrapping from 2^ID_WIDTH-1 to 1 (0 never issued).
- After the last message: go to GAP, load MIN_GAP_CYCLES-1, count down to 0, then IDLE. If MIN_GAP_CYCLES==0, go directly to IDLE.
- Latency: quote sampled at edge k with FSM idle and gap 0 → first o_order_valid high after edge k+2. Back-to-back messages possible with ready held high (one message per cycle).
- o_order_valid must not drop without a handshake. Reset mid-sequence abandons the message and clears all live state.
- Counters saturate at 16'hFFFF.

Decomposition:
- Package quote_pkg: order_type_e (NEW, CANCEL), side_e (BID, ASK), dispatcher state enum, and a message struct (type, side, price, qty, id).
- Sub-module sat_counter (parameterised width, inc, async active-low reset), instantiated for drop and reject counts.
- FSM, intake and ID logic live in this module.

Test Plan (MIN_GAP_CYCLES=8, PRICE_TOL=0, ready high unless stated):
1. Reset, then quote 100/102 qty 10 → NEW bid 100 qty10 id1, then NEW ask 102 qty10 id2 on consecutive cycles; first valid 2 edges after the sample; then 8 GAP cycles.
2. After case 1, quote 100/103 → CANCEL ask id2 (price 0, qty 0), then NEW ask 103 id3; no bid messages. Repeating 100/103 → no messages, o_busy returns low immediately.
3. Hold ready low for 5 cycles on the first message of case 1 → valid and payload stable for 5 cycles; the message is sent once when ready rises.
4. During busy, pulse quotes 101/104, 102/105, 103/106 → drop_count=2; the next sequence uses 103/106 (CXL bid, NEW bid 103, CXL ask, NEW ask 106).
5. Quote 105/104, then 0/10 → no messages, reject_count=2, pending unchanged.
6. Assert i_rst_n low mid-sequence (valid high) → all outputs 0 immediately. After release, quote 50/60 → NEW bid id1, NEW ask id2, no cancels.

Source files
------------

// File: rtl/quote_pkg.sv
// -----------------------------------------------------------------------------
// quote_pkg
// Shared types for the quote order dispatcher: order type and side encodings,
// the dispatcher state enum, the outgoing message record, and small helpers
// that map the per-sequence "to do" mask onto message states.
//
// The message record is sized by the MSG_*_W localparams. The dispatcher's
// DATA_WIDTH / QTY_WIDTH / ID_WIDTH parameters default to these widths and
// must not exceed them.
// -----------------------------------------------------------------------------
package quote_pkg;

    localparam int MSG_PRICE_W = 32;
    localparam int MSG_QTY_W   = 16;
    localparam int MSG_ID_W    = 16;

    typedef enum logic {
        ORD_NEW    = 1'b0,
        ORD_CANCEL = 1'b1
    } order_type_e;

    typedef enum logic {
        SIDE_BID = 1'b0,
        SIDE_ASK = 1'b1
    } side_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CXL_BID = 3'd1,
        ST_NEW_BID = 3'd2,
        ST_CXL_ASK = 3'd3,
        ST_NEW_ASK = 3'd4,
        ST_GAP     = 3'd5
    } disp_state_e;

    typedef struct packed {
        order_type_e            otype;
        side_e                  side;
        logic [MSG_PRICE_W-1:0] price;
        logic [MSG_QTY_W-1:0]   qty;
        logic [MSG_ID_W-1:0]    id;
    } order_msg_t;

    // To-do mask layout: [0] cancel bid, [1] new bid, [2] cancel ask,
    // [3] new ask. Bit order equals the mandatory message order.
    function automatic disp_state_e first_todo(input logic [3:0] todo);
        disp_state_e s;
        if (todo[0])      s = ST_CXL_BID;
        else if (todo[1]) s = ST_NEW_BID;
        else if (todo[2]) s = ST_CXL_ASK;
        else if (todo[3]) s = ST_NEW_ASK;
        else              s = ST_IDLE;
        return s;
    endfunction

    function automatic logic [3:0] todo_bit(input disp_state_e s);
        logic [3:0] m;
        case (s)
            ST_CXL_BID: m = 4'b0001;
            ST_NEW_BID: m = 4'b0010;
            ST_CXL_ASK: m = 4'b0100;
            ST_NEW_ASK: m = 4'b1000;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that increments by one on i_inc and sticks at all-ones.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (count cleared to 0)
//   i_inc    increment request for this cycle
//   o_count  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;

    // NOTE: clocked state is only ever assigned with <=, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/quote_order_dispatcher.sv
// -----------------------------------------------------------------------------
// quote_order_dispatcher
// Turns validated bid/ask quote pairs into a serial CANCEL/NEW order stream.
// A single-entry pending slot keeps only the newest accepted quote; the FSM
// consumes it when idle, works out which sides moved against the live orders,
// and emits the needed messages in the order cancel-bid, new-bid, cancel-ask,
// new-ask. A quiet gap follows every sequence that sent something.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_buy_price/i_ask_price/i_quote_qty/i_data_valid
//                         quote input, single-cycle pulse, no backpressure
//   o_order_valid/i_order_ready
//                         message handshake
//   o_order_type/o_order_side/o_order_price/o_order_qty/o_order_id
//                         registered message payload
//   o_busy                FSM not idle
//   o_drop_count          saturating count of overwritten pending quotes
//   o_reject_count        saturating count of rejected quotes
// -----------------------------------------------------------------------------
module quote_order_dispatcher
    import quote_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = MSG_PRICE_W,
    parameter int unsigned QTY_WIDTH      = MSG_QTY_W,
    parameter int unsigned ID_WIDTH       = MSG_ID_W,
    parameter int unsigned MIN_GAP_CYCLES = 8,
    parameter int unsigned PRICE_TOL      = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_buy_price,
    input  logic [DATA_WIDTH-1:0] i_ask_price,
    input  logic [QTY_WIDTH-1:0]  i_quote_qty,
    input  logic                  i_data_valid,
    output logic                  o_order_valid,
    input  logic                  i_order_ready,
    output logic                  o_order_type,
    output logic                  o_order_side,
    output logic [DATA_WIDTH-1:0] o_order_price,
    output logic [QTY_WIDTH-1:0]  o_order_qty,
    output logic [ID_WIDTH-1:0]   o_order_id,
    output logic                  o_busy,
    output logic [15:0]           o_drop_count,
    output logic [15:0]           o_reject_count
);

    localparam int unsigned GAP_W    = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;
    localparam int unsigned GAP_LOAD = (MIN_GAP_CYCLES > 0) ? MIN_GAP_CYCLES - 1 : 0;
    localparam logic [ID_WIDTH-1:0] ID_MAX = '1;

    // Pending slot
    logic                  pend_valid_q, pend_valid_d;
    logic [DATA_WIDTH-1:0] pend_bid_q,   pend_bid_d;
    logic [DATA_WIDTH-1:0] pend_ask_q,   pend_ask_d;
    logic [QTY_WIDTH-1:0]  pend_qty_q,   pend_qty_d;

    // Quote being worked on by the current sequence
    logic [DATA_WIDTH-1:0] cur_bid_q, cur_bid_d;
    logic [DATA_WIDTH-1:0] cur_ask_q, cur_ask_d;
    logic [QTY_WIDTH-1:0]  cur_qty_q, cur_qty_d;
    logic [3:0]            todo_q,    todo_d;

    // Live order book and ID allocator
    logic [ID_WIDTH-1:0]   live_bid_id_q, live_bid_id_d;
    logic [ID_WIDTH-1:0]   live_ask_id_q, live_ask_id_d;
    logic [DATA_WIDTH-1:0] live_bid_px_q, live_bid_px_d;
    logic [DATA_WIDTH-1:0] live_ask_px_q, live_ask_px_d;
    logic [ID_WIDTH-1:0]   next_id_q,     next_id_d;

    disp_state_e           state_q, state_d;
    logic [GAP_W-1:0]      gap_q,   gap_d;
    logic                  valid_q, valid_d;
    order_msg_t            msg_q,   msg_d, next_msg;
    logic                  load_msg;

    logic quote_ok, reject_inc, drop_inc, consume, handshake;
    logic bid_chg, ask_chg;
    logic [3:0] new_todo, todo_left;
    disp_state_e after_step;

    function automatic logic moved(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return diff > DATA_WIDTH'(PRICE_TOL);
    endfunction

    // ---------------- intake ----------------
    assign quote_ok   = i_data_valid && (i_buy_price != '0) && (i_buy_price < i_ask_price);
    assign reject_inc = i_data_valid && !quote_ok;
    assign consume    = (state_q == ST_IDLE) && pend_valid_q && (gap_q == '0);
    // A write landing in the consume cycle replaces nothing that is still waiting.
    assign drop_inc   = quote_ok && pend_valid_q && !consume;
    assign handshake  = valid_q && i_order_ready;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_bid_d   = pend_bid_q;
        pend_ask_d   = pend_ask_q;
        pend_qty_d   = pend_qty_q;
        if (consume) begin
            pend_valid_d = 1'b0;
        end
        if (quote_ok) begin
            pend_valid_d = 1'b1;
            pend_bid_d   = i_buy_price;
            pend_ask_d   = i_ask_price;
            pend_qty_d   = i_quote_qty;
        end
    end

    // Side change decision is taken against the live book at consume time.
    assign bid_chg  = (live_bid_id_q == '0) || moved(pend_bid_q, live_bid_px_q);
    assign ask_chg  = (live_ask_id_q == '0) || moved(pend_ask_q, live_ask_px_q);
    assign new_todo = {ask_chg, ask_chg && (live_ask_id_q != '0),
                       bid_chg, bid_chg && (live_bid_id_q != '0)};

    assign todo_left  = todo_q & ~todo_bit(state_q);
    assign after_step = first_todo(todo_left);

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        valid_d       = valid_q;
        load_msg      = 1'b0;
        todo_d        = todo_q;
        cur_bid_d     = cur_bid_q;
        cur_ask_d     = cur_ask_q;
        cur_qty_d     = cur_qty_q;
        live_bid_id_d = live_bid_id_q;
        live_ask_id_d = live_ask_id_q;
        live_bid_px_d = live_bid_px_q;
        live_ask_px_d = live_ask_px_q;
        next_id_d     = next_id_q;

        unique case (state_q)
            ST_IDLE: begin
                if (consume) begin
                    cur_bid_d = pend_bid_q;
                    cur_ask_d = pend_ask_q;
                    cur_qty_d = pend_qty_q;
                    todo_d    = new_todo;
                    // No change on either side leaves the FSM in IDLE.
                    state_d   = first_todo(new_todo);
                end
            end

            ST_CXL_BID, ST_NEW_BID, ST_CXL_ASK, ST_NEW_ASK: begin
                if (!valid_q) begin
                    // First cycle after the latch: present the first message.
                    valid_d  = 1'b1;
                    load_msg = 1'b1;
                end else if (handshake) begin
                    case (state_q)
                        ST_CXL_BID: live_bid_id_d = '0;
                        ST_CXL_ASK: live_ask_id_d = '0;
                        ST_NEW_BID: begin
                            live_bid_id_d = next_id_q;
                            live_bid_px_d = cur_bid_q;
                        end
                        default: begin
                            live_ask_id_d = next_id_q;
                            live_ask_px_d = cur_ask_q;
                        end
                    endcase
                    if ((state_q == ST_NEW_BID) || (state_q == ST_NEW_ASK)) begin
                        next_id_d = (next_id_q == ID_MAX) ? ID_WIDTH'(1)
                                                          : next_id_q + ID_WIDTH'(1);
                    end
                    todo_d = todo_left;
                    if (after_step != ST_IDLE) begin
                        // Load the following message on the same edge so a
                        // ready-high sink takes one message per cycle.
                        state_d  = after_step;
                        load_msg = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        if (MIN_GAP_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = GAP_W'(GAP_LOAD);
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Payload for the message state being entered; NEW uses the post-increment ID.
    always_comb begin
        next_msg = '0;
        case (state_d)
            ST_CXL_BID: begin
                next_msg.otype = ORD_CANCEL;
                next_msg.side  = SIDE_BID;
                next_msg.id    = MSG_ID_W'(live_bid_id_q);
            end
            ST_NEW_BID: begin
                next_msg.otype = ORD_NEW;
                next_msg.side  = SIDE_BID;
                next_msg.price = MSG_PRICE_W'(cur_bid_q);
                next_msg.qty   = MSG_QTY_W'(cur_qty_q);
                next_msg.id    = MSG_ID_W'(next_id_d);
            end
            ST_CXL_ASK: begin
                next_msg.otype = ORD_CANCEL;
                next_msg.side  = SIDE_ASK;
                next_msg.id    = MSG_ID_W'(live_ask_id_q);
            end
            ST_NEW_ASK: begin
                next_msg.otype = ORD_NEW;
                next_msg.side  = SIDE_ASK;
                next_msg.price = MSG_PRICE_W'(cur_ask_q);
                next_msg.qty   = MSG_QTY_W'(cur_qty_q);
                next_msg.id    = MSG_ID_W'(next_id_d);
            end
            default: ;
        endcase
        msg_d = load_msg ? next_msg : msg_q;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            gap_q         <= '0;
            valid_q       <= 1'b0;
            msg_q         <= '0;
            todo_q        <= '0;
            pend_valid_q  <= 1'b0;
            pend_bid_q    <= '0;
            pend_ask_q    <= '0;
            pend_qty_q    <= '0;
            cur_bid_q     <= '0;
            cur_ask_q     <= '0;
            cur_qty_q     <= '0;
            live_bid_id_q <= '0;
            live_ask_id_q <= '0;
            live_bid_px_q <= '0;
            live_ask_px_q <= '0;
            next_id_q     <= ID_WIDTH'(1);
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            valid_q       <= valid_d;
            msg_q         <= msg_d;
            todo_q        <= todo_d;
            pend_valid_q  <= pend_valid_d;
            pend_bid_q    <= pend_bid_d;
            pend_ask_q    <= pend_ask_d;
            pend_qty_q    <= pend_qty_d;
            cur_bid_q     <= cur_bid_d;
            cur_ask_q     <= cur_ask_d;
            cur_qty_q     <= cur_qty_d;
            live_bid_id_q <= live_bid_id_d;
            live_ask_id_q <= live_ask_id_d;
            live_bid_px_q <= live_bid_px_d;
            live_ask_px_q <= live_ask_px_d;
            next_id_q     <= next_id_d;
        end
    end

    sat_counter #(.WIDTH(16)) u_drop_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (drop_inc),
        .o_count (o_drop_count)
    );

    sat_counter #(.WIDTH(16)) u_reject_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (reject_inc),
        .o_count (o_reject_count)
    );

    assign o_order_valid = valid_q;
    assign o_order_type  = msg_q.otype;
    assign o_order_side  = msg_q.side;
    assign o_order_price = DATA_WIDTH'(msg_q.price);
    assign o_order_qty   = QTY_WIDTH'(msg_q.qty);
    assign o_order_id    = ID_WIDTH'(msg_q.id);
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_quote_order_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_quote_order_dispatcher
// Directed scenarios followed by random quotes/ready, all compared against a
// message-queue reference model of the dispatcher's rules.
// -----------------------------------------------------------------------------
module tb_quote_order_dispatcher;

    localparam int unsigned GAP = 8;
    localparam int unsigned TOL = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_buy_price = '0;
    logic [31:0] i_ask_price = '0;
    logic [15:0] i_quote_qty = '0;
    logic        i_data_valid = 1'b0;
    logic        i_order_ready = 1'b1;
    logic        o_order_valid, o_order_type, o_order_side, o_busy;
    logic [31:0] o_order_price;
    logic [15:0] o_order_qty, o_order_id, o_drop_count, o_reject_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    quote_order_dispatcher #(
        .DATA_WIDTH(32), .QTY_WIDTH(16), .ID_WIDTH(16),
        .MIN_GAP_CYCLES(GAP), .PRICE_TOL(TOL)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_buy_price    (i_buy_price),
        .i_ask_price    (i_ask_price),
        .i_quote_qty    (i_quote_qty),
        .i_data_valid   (i_data_valid),
        .o_order_valid  (o_order_valid),
        .i_order_ready  (i_order_ready),
        .o_order_type   (o_order_type),
        .o_order_side   (o_order_side),
        .o_order_price  (o_order_price),
        .o_order_qty    (o_order_qty),
        .o_order_id     (o_order_id),
        .o_busy         (o_busy),
        .o_drop_count   (o_drop_count),
        .o_reject_count (o_reject_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          typ;   // 1 = cancel
        bit          side;  // 1 = ask
        int unsigned price;
        int unsigned qty;
        int unsigned id;
    } exp_msg_t;

    exp_msg_t    exp_q[$];
    bit          m_pend_v;
    int unsigned m_pend_bid, m_pend_ask, m_pend_qty;
    int unsigned m_live_id[2];
    int unsigned m_live_px[2];
    int unsigned m_next_id, m_drop, m_rej;
    int          m_phase;   // 0 idle, 1 latching, 2 sending, 3 quiet gap
    int          m_gap;

    function automatic int unsigned id_after(input int unsigned id);
        return (id == 65535) ? 1 : id + 1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pend_v = 0; m_pend_bid = 0; m_pend_ask = 0; m_pend_qty = 0;
        m_live_id[0] = 0; m_live_id[1] = 0; m_live_px[0] = 0; m_live_px[1] = 0;
        m_next_id = 1; m_drop = 0; m_rej = 0; m_phase = 0; m_gap = 0;
    endtask

    task automatic model_plan();
        int unsigned nid = m_next_id;
        for (int s = 0; s < 2; s++) begin
            int unsigned px   = (s == 1) ? m_pend_ask : m_pend_bid;
            int unsigned diff = (px > m_live_px[s]) ? px - m_live_px[s] : m_live_px[s] - px;
            if (m_live_id[s] == 0 || diff > TOL) begin
                if (m_live_id[s] != 0)
                    exp_q.push_back('{1'b1, bit'(s), 0, 0, m_live_id[s]});
                exp_q.push_back('{1'b0, bit'(s), px, m_pend_qty, nid});
                nid = id_after(nid);
            end
        end
    endtask

    task automatic model_step();
        exp_msg_t m;
        case (m_phase)
            0: if (m_pend_v) begin
                model_plan();
                m_pend_v = 0;
                if (exp_q.size() != 0) m_phase = 1;
            end
            1: m_phase = 2;
            2: if (i_order_ready) begin
                m = exp_q.pop_front();
                if (m.typ) m_live_id[m.side] = 0;
                else begin
                    m_live_id[m.side] = m.id;
                    m_live_px[m.side] = m.price;
                    m_next_id = id_after(m.id);
                end
                if (exp_q.size() == 0) begin
                    m_phase = 3;
                    m_gap = GAP;
                end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) m_phase = 0;
            end
        endcase
        if (i_data_valid) begin
            if (i_buy_price == 0 || i_buy_price >= i_ask_price) begin
                if (m_rej < 65535) m_rej++;
            end else begin
                if (m_pend_v && m_drop < 65535) m_drop++;
                m_pend_v = 1;
                m_pend_bid = i_buy_price;
                m_pend_ask = i_ask_price;
                m_pend_qty = i_quote_qty;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Continuous comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("valid", o_order_valid, m_phase == 2);
            if (m_phase == 2 && exp_q.size() != 0) begin
                check("type",  o_order_type,  exp_q[0].typ);
                check("side",  o_order_side,  exp_q[0].side);
                check("price", o_order_price, exp_q[0].price);
                check("qty",   o_order_qty,   exp_q[0].qty);
                check("id",    o_order_id,    exp_q[0].id);
            end
            check("busy",   o_busy,         m_phase != 0);
            check("drops",  o_drop_count,   m_drop);
            check("reject", o_reject_count, m_rej);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quote(input int unsigned bid, input int unsigned ask, input int unsigned qty);
        i_data_valid = 1'b1;
        i_buy_price  = bid;
        i_ask_price  = ask;
        i_quote_qty  = 16'(qty);
        tick();
        i_data_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        i_data_valid = 1'b0;
        i_order_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_order_valid && n < 20) begin
            tick();
            n++;
        end
        if (!o_order_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_msg(input string tag, input bit typ, input bit side,
                             input int unsigned price, input int unsigned qty,
                             input int unsigned id);
        check({tag, "_valid"}, o_order_valid, 1);
        check({tag, "_type"},  o_order_type,  typ);
        check({tag, "_side"},  o_order_side,  side);
        check({tag, "_price"}, o_order_price, price);
        check({tag, "_qty"},   o_order_qty,   qty);
        check({tag, "_id"},    o_order_id,    id);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_valid", o_order_valid, 0);
        check("rst_busy",  o_busy, 0);
        check("rst_id",    o_order_id, 0);
        check("rst_drop",  o_drop_count, 0);

        // 1: first quote -> two NEWs, latency 2 edges, 8 gap cycles
        drive_quote(100, 102, 10);
        tick();
        check("t1_lat", o_order_valid, 0);
        tick();
        check_msg("t1_newbid", 0, 0, 100, 10, 1);
        tick();
        check_msg("t1_newask", 0, 1, 102, 10, 2);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t1_gap_busy", o_busy, 1);
            check("t1_gap_valid", o_order_valid, 0);
        end
        tick();
        check("t1_idle", o_busy, 0);

        // 2: ask moves -> cancel + new ask only; repeat -> nothing
        drive_quote(100, 103, 10);
        tick();
        tick();
        check_msg("t2_cxlask", 1, 1, 0, 0, 2);
        tick();
        check_msg("t2_newask", 0, 1, 103, 10, 3);
        repeat (9) tick();
        check("t2_idle", o_busy, 0);
        drive_quote(100, 103, 10);
        for (int i = 0; i < 3; i++) begin
            check("t2_same_busy", o_busy, 0);
            check("t2_same_valid", o_order_valid, 0);
            tick();
        end

        // 3: ready low 5 cycles on first message
        apply_reset();
        i_order_ready = 1'b0;
        drive_quote(100, 102, 10);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_msg("t3_hold", 0, 0, 100, 10, 1);
        end
        i_order_ready = 1'b1;
        tick();
        check_msg("t3_next", 0, 1, 102, 10, 2);
        tick();
        check("t3_done", o_order_valid, 0);

        // 4: three quotes while busy -> two drops, newest used
        drive_quote(101, 104, 11);
        drive_quote(102, 105, 12);
        drive_quote(103, 106, 13);
        check("t4_drops", o_drop_count, 2);
        wait_valid("t4");
        check_msg("t4_cxlbid", 1, 0, 0, 0, 1);
        tick();
        check_msg("t4_newbid", 0, 0, 103, 13, 3);
        tick();
        check_msg("t4_cxlask", 1, 1, 0, 0, 2);
        tick();
        check_msg("t4_newask", 0, 1, 106, 13, 4);
        repeat (10) tick();

        // 5: crossed and zero-bid quotes are rejected
        drive_quote(105, 104, 1);
        drive_quote(0, 10, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_valid", o_order_valid, 0);
            check("t5_busy", o_busy, 0);
        end
        check("t5_reject", o_reject_count, 2);
        check("t5_drops", o_drop_count, 2);

        // 6: reset mid-sequence, then fresh IDs
        drive_quote(200, 210, 5);
        wait_valid("t6");
        rst_n = 1'b0;
        #1;
        check("t6_valid", o_order_valid, 0);
        check("t6_price", o_order_price, 0);
        check("t6_id",    o_order_id, 0);
        check("t6_busy",  o_busy, 0);
        check("t6_rej",   o_reject_count, 0);
        check("t6_drop",  o_drop_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        drive_quote(50, 60, 7);
        tick();
        tick();
        check_msg("t6_newbid", 0, 0, 50, 7, 1);
        tick();
        check_msg("t6_newask", 0, 1, 60, 7, 2);
        repeat (10) tick();

        // Random traffic against the model
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            i_data_valid  = ($urandom_range(0, 3) == 0);
            i_buy_price   = $urandom_range(0, 20);
            i_ask_price   = $urandom_range(0, 24);
            i_quote_qty   = 16'($urandom);
            i_order_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        i_data_valid = 1'b0;
        i_order_ready = 1'b1;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
